// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / load-use hazard unit.
// Select codes: 0 picks the register file, k+1 picks forwarding stage k.
package fwd_pkg;

  localparam int SEL_RF     = 0;
  localparam int MAX_STAGES = 8;
  localparam int MAX_DW     = 64;
  localparam int MUX_IW     = $clog2(MAX_STAGES * MAX_DW);

  // "No write" destination code for a register address of width aw (all ones).
  function automatic logic [31:0] null_reg(input int aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // Callers zero-extend rf/stg to the maximum widths and truncate the result.
  function automatic logic [MAX_DW-1:0] fwd_mux(
    input int                             sel,
    input logic [MAX_DW-1:0]              rf,
    input logic [MAX_STAGES*MAX_DW-1:0]   stg,
    input int                             dw
  );
    logic [MUX_IW-1:0] base;
    if (sel == SEL_RF || sel > MAX_STAGES) begin
      return rf;
    end
    base = MUX_IW'((sel - 1) * dw);
    return stg[base +: MAX_DW];
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Priority matcher: youngest tracker stage holding the requested register wins.
// Masked stages (a load still in stage 0) are skipped so selection falls through.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int                 REG_AW   = 4,
  parameter int                 STAGES   = 2,
  parameter logic [REG_AW-1:0]  NULL_REG = REG_AW'(null_reg(REG_AW)),
  parameter int                 SEL_W    = sel_width(STAGES)
) (
  input  logic [REG_AW-1:0]         addr,
  input  logic [STAGES*REG_AW-1:0]  wregs,
  input  logic [STAGES-1:0]         mask,
  output logic [SEL_W-1:0]          sel
);

  logic [STAGES-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_hit
      assign hit[gi] = (wregs[gi*REG_AW +: REG_AW] == addr) &&
                       (wregs[gi*REG_AW +: REG_AW] != NULL_REG) &&
                       !mask[gi];
    end
  endgenerate

  // Scan oldest to youngest so the last (youngest) hit overrides.
  always_comb begin
    sel = SEL_W'(SEL_RF);
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: destination tracker, per-operand forwarding
// selects and muxes, a one-cycle load-use stall and a saturating stall counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int                 REG_AW   = 4,
  parameter int                 DATA_W   = 16,
  parameter int                 STAGES   = 2,
  parameter logic [REG_AW-1:0]  NULL_REG = REG_AW'(null_reg(REG_AW)),
  parameter int                 SEL_W    = sel_width(STAGES),
  parameter int                 CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_AW-1:0]          id_r1,
  input  logic [REG_AW-1:0]          id_r2,
  input  logic                       id_r2_is_store,
  input  logic [REG_AW-1:0]          id_wreg,
  input  logic                       id_is_load,
  input  logic                       flush,
  input  logic [STAGES*DATA_W-1:0]   stg_data,
  input  logic [DATA_W-1:0]          rdata1,
  input  logic [DATA_W-1:0]          rdata2,
  output logic [SEL_W-1:0]           sel_a,
  output logic [SEL_W-1:0]           sel_b,
  output logic [SEL_W-1:0]           sel_st,
  output logic [DATA_W-1:0]          op_a,
  output logic [DATA_W-1:0]          op_b,
  output logic [DATA_W-1:0]          st_data,
  output logic                       stall,
  output logic [STAGES*REG_AW-1:0]   stg_wreg,
  output logic [CNT_W-1:0]           stall_cnt
);

  logic [STAGES*REG_AW-1:0] wreg_reg, wreg_next;
  logic [STAGES-1:0]        load_reg, load_next;
  logic [CNT_W-1:0]         stall_cnt_reg, stall_cnt_next;
  logic [STAGES-1:0]        ld_mask;
  logic [SEL_W-1:0]         sel_r1, sel_r2;
  logic                     hit0_r1, hit0_r2;
  logic                     stall_int, bubble;

  logic [MAX_STAGES*MAX_DW-1:0] stg_ext;
  logic [MAX_DW-1:0]            rf1_ext, rf2_ext;
  logic [MAX_DW-1:0]            res_a, res_b, res_st;

  assign hit0_r1 = (wreg_reg[REG_AW-1:0] == id_r1) && (wreg_reg[REG_AW-1:0] != NULL_REG);
  assign hit0_r2 = (wreg_reg[REG_AW-1:0] == id_r2) && (wreg_reg[REG_AW-1:0] != NULL_REG);

  // flush kills the ID instruction, so it also suppresses the stall it would cause.
  assign stall_int = id_valid & ~flush & load_reg[0] & (hit0_r1 | hit0_r2);
  assign bubble    = stall_int | flush | ~id_valid;

  assign wreg_next[REG_AW-1:0] = bubble ? NULL_REG : id_wreg;
  assign load_next[0]          = ~bubble & id_is_load;
  assign ld_mask[0]            = load_reg[0];

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_shift
      assign wreg_next[gi*REG_AW +: REG_AW] = wreg_reg[(gi-1)*REG_AW +: REG_AW];
      assign load_next[gi]                  = load_reg[gi-1];
      assign ld_mask[gi]                    = 1'b0;
    end
  endgenerate

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall_int && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wreg_reg      <= {STAGES{NULL_REG}};
      load_reg      <= '0;
      stall_cnt_reg <= '0;
    end else begin
      wreg_reg      <= wreg_next;
      load_reg      <= load_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  fwd_select #(
    .REG_AW   (REG_AW),
    .STAGES   (STAGES),
    .NULL_REG (NULL_REG),
    .SEL_W    (SEL_W)
  ) u_sel_a (
    .addr  (id_r1),
    .wregs (wreg_reg),
    .mask  (ld_mask),
    .sel   (sel_r1)
  );

  fwd_select #(
    .REG_AW   (REG_AW),
    .STAGES   (STAGES),
    .NULL_REG (NULL_REG),
    .SEL_W    (SEL_W)
  ) u_sel_b (
    .addr  (id_r2),
    .wregs (wreg_reg),
    .mask  (ld_mask),
    .sel   (sel_r2)
  );

  // Operand B's match feeds either the ALU operand or the store-data path, never both.
  assign sel_a  = sel_r1;
  assign sel_b  = id_r2_is_store ? SEL_W'(SEL_RF) : sel_r2;
  assign sel_st = id_r2_is_store ? sel_r2 : SEL_W'(SEL_RF);

  always_comb begin
    stg_ext                        = '0;
    stg_ext[STAGES*DATA_W-1:0]     = stg_data;
    rf1_ext                        = '0;
    rf1_ext[DATA_W-1:0]            = rdata1;
    rf2_ext                        = '0;
    rf2_ext[DATA_W-1:0]            = rdata2;
    res_a  = fwd_mux(32'(sel_a),  rf1_ext, stg_ext, DATA_W);
    res_b  = fwd_mux(32'(sel_b),  rf2_ext, stg_ext, DATA_W);
    res_st = fwd_mux(32'(sel_st), rf2_ext, stg_ext, DATA_W);
  end

  assign op_a      = res_a[DATA_W-1:0];
  assign op_b      = res_b[DATA_W-1:0];
  assign st_data   = res_st[DATA_W-1:0];
  assign stall     = stall_int;
  assign stg_wreg  = wreg_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
